// File: rtl/bcd_serial_assembler.sv
// Serial-to-parallel BCD digit assembler with registered valid/ready output.
// Optional out-of-range rejection enabled by defining BCD_RANGE_CHECK_EN.
module bcd_serial_assembler #(
  parameter int MSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
  input  logic       sin_valid,
  input  logic       sin_sync,
  output logic [3:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       frame_err,
  output logic       range_err,
  output logic       overrun
);

  logic [3:0] sh;
  logic [3:0] sh_nx;
  logic [1:0] cnt;
  logic [1:0] cnt_eff;
  logic       done;
  logic       drain;
  logic       bad;
  logic       load;
  logic       drop;
  logic       fe_nx;

  // Shift direction, sync-forced framing and completion detect
  always_comb begin
    cnt_eff = sin_sync ? 2'd0 : cnt;
    if (MSB_FIRST != 0) begin
      sh_nx = {sh[2:0], sin};
    end else begin
      sh_nx = {sin, sh[3:1]};
    end
    done  = sin_valid && (cnt_eff == 2'd3);
    drain = dout_valid && dout_ready;
    fe_nx = sin_valid && sin_sync && (cnt != 2'd0);
  end

`ifdef BCD_RANGE_CHECK_EN
  assign bad = (sh_nx > 4'd9);
`else
  assign bad = 1'b0;
`endif

  // A completed digit either loads, is rejected, or overruns
  always_comb begin
    load = 1'b0;
    drop = 1'b0;
    if (done && !bad) begin
      if (!dout_valid || drain) begin
        load = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
  end

  // Bit collection state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh  <= 4'd0;
      cnt <= 2'd0;
    end else if (sin_valid) begin
      sh  <= sh_nx;
      cnt <= cnt_eff + 2'd1;
    end
  end

  // Output register and handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= 4'd0;
      dout_valid <= 1'b0;
    end else if (load) begin
      dout       <= sh_nx;
      dout_valid <= 1'b1;
    end else if (drain) begin
      dout_valid <= 1'b0;
    end
  end

  // One-cycle error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= fe_nx;
      overrun   <= drop;
    end
  end

`ifdef BCD_RANGE_CHECK_EN
  // Out-of-range pulse for rejected codes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_err <= 1'b0;
    end else begin
      range_err <= done && bad;
    end
  end
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_assembler.sv
// Directed bench for bcd_serial_assembler.
// Runs an MSB-first and an LSB-first instance on shared stimulus.
module tb_bcd_serial_assembler;

  logic       clk;
  logic       rst_n;
  logic       sin;
  logic       sin_valid;
  logic       sin_sync;
  logic       dout_ready;
  logic [3:0] m_dout;
  logic       m_dv;
  logic       m_fe;
  logic       m_re;
  logic       m_ov;
  logic [3:0] l_dout;
  logic       l_dv;
  logic       l_fe;
  logic       l_re;
  logic       l_ov;

  int tests;
  int fails;

  bcd_serial_assembler #(.MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid),
    .sin_sync(sin_sync), .dout(m_dout), .dout_valid(m_dv),
    .dout_ready(dout_ready), .frame_err(m_fe), .range_err(m_re),
    .overrun(m_ov)
  );

  bcd_serial_assembler #(.MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid),
    .sin_sync(sin_sync), .dout(l_dout), .dout_valid(l_dv),
    .dout_ready(dout_ready), .frame_err(l_fe), .range_err(l_re),
    .overrun(l_ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sin = 0; sin_valid = 0; sin_sync = 0; dout_ready = 1;
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    step();
  endtask

  task automatic send_bit(input logic b, input logic s);
    sin = b; sin_valid = 1; sin_sync = s;
    step();
    sin_valid = 0; sin_sync = 0;
  endtask

  // MSB-first: bit 3 goes first
  task automatic send_msb(input logic [3:0] d);
    for (int i = 3; i >= 0; i--) send_bit(d[i], 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({m_dout, m_dv, m_fe, m_re, m_ov} !== 8'h00) begin
      fails++;
      $display("FAIL reset_msb got=%b want=00000000",
               {m_dout, m_dv, m_fe, m_re, m_ov});
    end
    tests++;
    if ({l_dout, l_dv, l_fe, l_re, l_ov} !== 8'h00) begin
      fails++;
      $display("FAIL reset_lsb got=%b want=00000000",
               {l_dout, l_dv, l_fe, l_re, l_ov});
    end
  endtask

  task automatic test_msb_first();
    logic [3:0] bits;
    do_reset();
    bits = 4'b0111;
    for (int i = 3; i >= 1; i--) send_bit(bits[i], 1'b0);
    tests++;
    if (m_dv !== 1'b0) begin
      fails++;
      $display("FAIL msb_early_valid got=%b want=0", m_dv);
    end
    send_bit(bits[0], 1'b0);
    tests++;
    if (m_dv !== 1'b1 || m_dout !== 4'b0111) begin
      fails++;
      $display("FAIL msb_digit got=%b/%b want=1/0111", m_dv, m_dout);
    end
    step();
    tests++;
    if (m_dv !== 1'b0 || m_dout !== 4'b0111) begin
      fails++;
      $display("FAIL msb_one_cycle got=%b/%b want=0/0111", m_dv, m_dout);
    end
  endtask

  task automatic test_lsb_first_gaps();
    logic [3:0] seq;
    logic       err;
    do_reset();
    seq = 4'b1001;
    err = 0;
    for (int i = 0; i < 4; i++) begin
      send_bit(seq[i], 1'b0);
      err |= l_fe | l_re | l_ov;
      if (i < 3) begin
        step(); err |= l_fe | l_re | l_ov;
        step(); err |= l_fe | l_re | l_ov;
      end
    end
    tests++;
    if (l_dv !== 1'b1 || l_dout !== 4'b1001) begin
      fails++;
      $display("FAIL lsb_digit got=%b/%b want=1/1001", l_dv, l_dout);
    end
    step();
    err |= l_fe | l_re | l_ov;
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL lsb_no_err got=%b want=0", err);
    end
  endtask

  task automatic test_frame_err();
    do_reset();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    tests++;
    if (m_fe !== 1'b1) begin
      fails++;
      $display("FAIL frame_pulse got=%b want=1", m_fe);
    end
    send_bit(1'b1, 1'b0);
    tests++;
    if (m_fe !== 1'b0) begin
      fails++;
      $display("FAIL frame_once got=%b want=0", m_fe);
    end
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    tests++;
    if (m_dv !== 1'b1 || m_dout !== 4'b0101) begin
      fails++;
      $display("FAIL frame_digit got=%b/%b want=1/0101", m_dv, m_dout);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    dout_ready = 0;
    send_msb(4'b0011);
    tests++;
    if (m_dv !== 1'b1 || m_dout !== 4'b0011) begin
      fails++;
      $display("FAIL ovr_first got=%b/%b want=1/0011", m_dv, m_dout);
    end
    send_msb(4'b0100);
    tests++;
    if (m_ov !== 1'b1 || m_dout !== 4'b0011 || m_dv !== 1'b1) begin
      fails++;
      $display("FAIL ovr_pulse got=%b/%b/%b want=1/1/0011",
               m_ov, m_dv, m_dout);
    end
    step();
    tests++;
    if (m_ov !== 1'b0) begin
      fails++;
      $display("FAIL ovr_once got=%b want=0", m_ov);
    end
    dout_ready = 1;
    step();
    tests++;
    if (m_dv !== 1'b0 || m_dout !== 4'b0011) begin
      fails++;
      $display("FAIL ovr_drain got=%b/%b want=0/0011", m_dv, m_dout);
    end
  endtask

  task automatic test_range();
    do_reset();
    send_msb(4'b1100);
`ifdef BCD_RANGE_CHECK_EN
    tests++;
    if (m_re !== 1'b1 || m_dv !== 1'b0 || m_ov !== 1'b0) begin
      fails++;
      $display("FAIL range_reject got=%b/%b/%b want=1/0/0",
               m_re, m_dv, m_ov);
    end
`else
    tests++;
    if (m_re !== 1'b0 || m_dv !== 1'b1 || m_dout !== 4'b1100) begin
      fails++;
      $display("FAIL range_pass got=%b/%b/%b want=0/1/1100",
               m_re, m_dv, m_dout);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int good;
    logic [3:0] d;
    do_reset();
    good = 0;
    for (int k = 0; k < 10; k++) begin
      d = k[3:0];
      for (int i = 3; i >= 0; i--) begin
        send_bit(d[i], 1'b0);
        if (i != 0 && m_dv !== 1'b0) good = -100;
      end
      if (m_dv === 1'b1 && m_dout === d && m_ov === 1'b0) good++;
    end
    sin_valid = 0;
    tests++;
    if (good != 10) begin
      fails++;
      $display("FAIL stream_ten got=%0d want=10", good);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] d;
    do_reset();
    for (int k = 0; k < 5; k++) send_msb(k[3:0]);
    d = 4'd5;
    send_bit(d[3], 1'b0);
    send_bit(d[2], 1'b0);
    #2;
    rst_n = 0;
    #1;
    tests++;
    if ({m_dout, m_dv, m_fe, m_re, m_ov} !== 8'h00) begin
      fails++;
      $display("FAIL reset_mid got=%b want=00000000",
               {m_dout, m_dv, m_fe, m_re, m_ov});
    end
    step();
    rst_n = 1;
    step();
    send_msb(4'b0110);
    tests++;
    if (m_dv !== 1'b1 || m_dout !== 4'b0110) begin
      fails++;
      $display("FAIL after_reset got=%b/%b want=1/0110", m_dv, m_dout);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_msb_first();
    test_lsb_first_gaps();
    test_frame_err();
    test_overrun();
    test_range();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
